// File: rtl/rs_alu_pair_if.sv
// Bundles the dispatch, CDB and ALU-issue signals of the two-entry ALU reservation station.
// The master side is the issue queue, CDB and ALU environment. The slave side is the station.
interface rs_alu_pair_if #(
  parameter int XLEN = 32
);
  logic            disp_valid;
  logic [2:0]      disp_rs;
  logic [3:0]      disp_op;
  logic [XLEN-1:0] disp_vj;
  logic [XLEN-1:0] disp_vk;
  logic [2:0]      disp_qj;
  logic [2:0]      disp_qk;
  logic            cdb_valid;
  logic [2:0]      cdb_tag;
  logic [XLEN-1:0] cdb_data;
  logic            fu_ready;
  logic [1:0]      busy;
  logic            issue_valid;
  logic [3:0]      issue_op;
  logic [XLEN-1:0] issue_a;
  logic [XLEN-1:0] issue_b;
  logic [2:0]      issue_tag;

  modport master (
    output disp_valid, disp_rs, disp_op, disp_vj, disp_vk, disp_qj, disp_qk,
    output cdb_valid, cdb_tag, cdb_data, fu_ready,
    input  busy, issue_valid, issue_op, issue_a, issue_b, issue_tag
  );

  modport slave (
    input  disp_valid, disp_rs, disp_op, disp_vj, disp_vk, disp_qj, disp_qk,
    input  cdb_valid, cdb_tag, cdb_data, fu_ready,
    output busy, issue_valid, issue_op, issue_a, issue_b, issue_tag
  );
endinterface

// File: rtl/rs_alu_pair.sv
// Two-entry ALU reservation station. Entries capture operands at dispatch, wake up from the CDB,
// and issue oldest-first. An offer that the ALU stalls stays locked until the ALU accepts it.
module rs_alu_pair #(
  parameter logic [2:0] TAG_A = 3'd5,
  parameter logic [2:0] TAG_B = 3'd6,
  parameter int         XLEN  = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  rs_alu_pair_if.slave bus
);
  typedef enum logic [1:0] {ST_FREE = 2'd0, ST_WAIT = 2'd1, ST_READY = 2'd2} state_t;

  state_t          r_state [2];
  logic [3:0]      r_op    [2];
  logic [XLEN-1:0] r_vj    [2];
  logic [XLEN-1:0] r_vk    [2];
  logic [2:0]      r_qj    [2];
  logic [2:0]      r_qk    [2];
  logic            r_age   [2];
  logic            r_lock;
  logic            r_lock_sel;

  logic [2:0] w_tag    [2];
  logic [1:0] w_ready;
  logic       w_sel;
  logic       w_fire;
  logic       w_dj_hit;
  logic       w_dk_hit;
  logic       w_dj_ok;
  logic       w_dk_ok;
  logic [1:0] w_wj_hit;
  logic [1:0] w_wk_hit;

  // A zero tag never matches, so a valid operand is never overwritten.
  function automatic logic cdb_hit(input logic [2:0] q, input logic v, input logic [2:0] t);
    return v && (q != 3'd0) && (q == t);
  endfunction

  assign w_tag[0] = TAG_A;
  assign w_tag[1] = TAG_B;

  // Selection: a locked offer wins. Otherwise the older READY entry wins.
  // An entry's age bit is 1 when the other entry was dispatched after it.
  always_comb begin
    w_ready[0] = (r_state[0] == ST_READY);
    w_ready[1] = (r_state[1] == ST_READY);
    if (r_lock) begin
      w_sel = r_lock_sel;
    end else if (w_ready == 2'b11) begin
      w_sel = r_age[1];
    end else if (w_ready[1]) begin
      w_sel = 1'b1;
    end else begin
      w_sel = 1'b0;
    end
    w_fire = (|w_ready) && bus.fu_ready;
  end

  // CDB match detection for the dispatch operands and for the waiting entries.
  always_comb begin
    w_dj_hit = cdb_hit(bus.disp_qj, bus.cdb_valid, bus.cdb_tag);
    w_dk_hit = cdb_hit(bus.disp_qk, bus.cdb_valid, bus.cdb_tag);
    w_dj_ok  = w_dj_hit || (bus.disp_qj == 3'd0);
    w_dk_ok  = w_dk_hit || (bus.disp_qk == 3'd0);
    for (int i = 0; i < 2; i++) begin
      w_wj_hit[i] = cdb_hit(r_qj[i], bus.cdb_valid, bus.cdb_tag);
      w_wk_hit[i] = cdb_hit(r_qk[i], bus.cdb_valid, bus.cdb_tag);
    end
  end

  // Issue outputs are forced to zero whenever nothing is offered.
  always_comb begin
    bus.issue_valid = |w_ready;
    bus.issue_op    = 4'd0;
    bus.issue_a     = {XLEN{1'b0}};
    bus.issue_b     = {XLEN{1'b0}};
    bus.issue_tag   = 3'd0;
    if (|w_ready) begin
      bus.issue_op  = r_op[w_sel];
      bus.issue_a   = r_vj[w_sel];
      bus.issue_b   = r_vk[w_sel];
      bus.issue_tag = w_tag[w_sel];
    end else begin
      bus.issue_tag = 3'd0;
    end
  end

  assign bus.busy = {r_state[1] != ST_FREE, r_state[0] != ST_FREE};

  // Entry state. Dispatch is tested against the state before the edge,
  // so an entry freed by fire cannot be refilled in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= ST_FREE;
        r_op[i]    <= 4'd0;
        r_vj[i]    <= {XLEN{1'b0}};
        r_vk[i]    <= {XLEN{1'b0}};
        r_qj[i]    <= 3'd0;
        r_qk[i]    <= 3'd0;
        r_age[i]   <= 1'b0;
      end
      r_lock     <= 1'b0;
      r_lock_sel <= 1'b0;
    end else begin
      r_lock     <= (|w_ready) && !bus.fu_ready;
      r_lock_sel <= w_sel;
      for (int i = 0; i < 2; i++) begin
        if (w_fire && (w_sel == 1'(i))) begin
          r_state[i] <= ST_FREE;
          r_op[i]    <= 4'd0;
          r_vj[i]    <= {XLEN{1'b0}};
          r_vk[i]    <= {XLEN{1'b0}};
          r_qj[i]    <= 3'd0;
          r_qk[i]    <= 3'd0;
        end else if ((r_state[i] == ST_FREE) && bus.disp_valid && (bus.disp_rs == w_tag[i])) begin
          r_op[i]    <= bus.disp_op;
          r_vj[i]    <= w_dj_hit ? bus.cdb_data : bus.disp_vj;
          r_qj[i]    <= w_dj_hit ? 3'd0 : bus.disp_qj;
          r_vk[i]    <= w_dk_hit ? bus.cdb_data : bus.disp_vk;
          r_qk[i]    <= w_dk_hit ? 3'd0 : bus.disp_qk;
          r_state[i] <= (w_dj_ok && w_dk_ok) ? ST_READY : ST_WAIT;
          r_age[i]   <= 1'b0;
          r_age[i^1] <= 1'b1;
        end else if (r_state[i] == ST_WAIT) begin
          if (w_wj_hit[i]) begin
            r_vj[i] <= bus.cdb_data;
            r_qj[i] <= 3'd0;
          end
          if (w_wk_hit[i]) begin
            r_vk[i] <= bus.cdb_data;
            r_qk[i] <= 3'd0;
          end
          if ((w_wj_hit[i] || (r_qj[i] == 3'd0)) && (w_wk_hit[i] || (r_qk[i] == 3'd0))) begin
            r_state[i] <= ST_READY;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_alu_pair.sv
// Testbench for rs_alu_pair: directed vector table, hand-written multi-cycle sequences,
// and a randomized run checked against a transaction-level reference model.
module tb_rs_alu_pair;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_alu_pair_if #(.XLEN(XLEN)) bus ();

  rs_alu_pair #(.TAG_A(3'd5), .TAG_B(3'd6), .XLEN(XLEN)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic dv; logic [2:0] rs; logic [3:0] op; logic [31:0] vj; logic [31:0] vk;
    logic [2:0] qj; logic [2:0] qk; logic cv; logic [2:0] ct; logic [31:0] cd; logic fu;
    logic [1:0] eb; logic ev; logic [3:0] eo; logic [31:0] ea; logic [31:0] ebv; logic [2:0] et;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic dv, input logic [2:0] rs, input logic [3:0] op,
                              input logic [31:0] vj, input logic [31:0] vk,
                              input logic [2:0] qj, input logic [2:0] qk,
                              input logic cv, input logic [2:0] ct, input logic [31:0] cd,
                              input logic fu, input logic [1:0] eb, input logic ev,
                              input logic [3:0] eo, input logic [31:0] ea,
                              input logic [31:0] ebv, input logic [2:0] et);
    vec_t v;
    v.dv = dv; v.rs = rs; v.op = op; v.vj = vj; v.vk = vk; v.qj = qj; v.qk = qk;
    v.cv = cv; v.ct = ct; v.cd = cd; v.fu = fu;
    v.eb = eb; v.ev = ev; v.eo = eo; v.ea = ea; v.ebv = ebv; v.et = et;
    return v;
  endfunction

  task automatic drv(input logic dv, input logic [2:0] rs, input logic [3:0] op,
                     input logic [31:0] vj, input logic [31:0] vk,
                     input logic [2:0] qj, input logic [2:0] qk,
                     input logic cv, input logic [2:0] ct, input logic [31:0] cd, input logic fu);
    bus.disp_valid = dv; bus.disp_rs = rs; bus.disp_op = op;
    bus.disp_vj = vj; bus.disp_vk = vk; bus.disp_qj = qj; bus.disp_qk = qk;
    bus.cdb_valid = cv; bus.cdb_tag = ct; bus.cdb_data = cd; bus.fu_ready = fu;
  endtask

  task automatic check(input string name, input logic [1:0] eb, input logic ev,
                       input logic [3:0] eo, input logic [31:0] ea,
                       input logic [31:0] ebv, input logic [2:0] et);
    logic [73:0] act;
    logic [73:0] exp;
    act = {bus.busy, bus.issue_valid, bus.issue_op, bus.issue_a, bus.issue_b, bus.issue_tag};
    exp = {eb, ev, eo, ea, ebv, et};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got busy=%b valid=%b op=%h a=%h b=%h tag=%0d, expected busy=%b valid=%b op=%h a=%h b=%h tag=%0d",
               name, bus.busy, bus.issue_valid, bus.issue_op, bus.issue_a, bus.issue_b,
               bus.issue_tag, eb, ev, eo, ea, ebv, et);
    end
  endtask

  // Transaction-level model. Each entry keeps a dispatch sequence number for age.
  // The held offer models an offer stalled by the ALU.
  logic        m_busy [2];
  logic [3:0]  m_op   [2];
  logic [31:0] m_vj   [2];
  logic [31:0] m_vk   [2];
  logic [2:0]  m_qj   [2];
  logic [2:0]  m_qk   [2];
  int          m_seq  [2];
  int          m_held;
  int          m_cnt;
  logic [2:0]  mt     [2];

  task automatic m_reset();
    for (int e = 0; e < 2; e++) begin
      m_busy[e] = 1'b0; m_op[e] = 4'd0; m_vj[e] = 32'd0; m_vk[e] = 32'd0;
      m_qj[e] = 3'd0; m_qk[e] = 3'd0; m_seq[e] = 0;
    end
    m_held = -1;
    m_cnt = 0;
  endtask

  function automatic int m_offer();
    int best;
    if (m_held >= 0) return m_held;
    best = -1;
    for (int e = 0; e < 2; e++) begin
      if (m_busy[e] && m_qj[e] == 3'd0 && m_qk[e] == 3'd0 && (best < 0 || m_seq[e] < m_seq[best]))
        best = e;
    end
    return best;
  endfunction

  task automatic m_check(input string name);
    int off;
    off = m_offer();
    if (off < 0)
      check(name, {m_busy[1], m_busy[0]}, 1'b0, 4'd0, 32'd0, 32'd0, 3'd0);
    else
      check(name, {m_busy[1], m_busy[0]}, 1'b1, m_op[off], m_vj[off], m_vk[off], mt[off]);
  endtask

  task automatic m_step();
    int   off;
    logic fire;
    off  = m_offer();
    fire = (off >= 0) && bus.fu_ready;
    for (int e = 0; e < 2; e++) begin
      if (fire && off == e) begin
        m_busy[e] = 1'b0;
      end else if (m_busy[e]) begin
        if (bus.cdb_valid && bus.cdb_tag != 3'd0 && m_qj[e] == bus.cdb_tag) begin
          m_vj[e] = bus.cdb_data; m_qj[e] = 3'd0;
        end
        if (bus.cdb_valid && bus.cdb_tag != 3'd0 && m_qk[e] == bus.cdb_tag) begin
          m_vk[e] = bus.cdb_data; m_qk[e] = 3'd0;
        end
      end else if (bus.disp_valid && bus.disp_rs == mt[e]) begin
        m_busy[e] = 1'b1;
        m_op[e] = bus.disp_op;
        m_seq[e] = m_cnt;
        m_cnt++;
        if (bus.disp_qj != 3'd0 && bus.cdb_valid && bus.cdb_tag == bus.disp_qj) begin
          m_vj[e] = bus.cdb_data; m_qj[e] = 3'd0;
        end else begin
          m_vj[e] = bus.disp_vj; m_qj[e] = bus.disp_qj;
        end
        if (bus.disp_qk != 3'd0 && bus.cdb_valid && bus.cdb_tag == bus.disp_qk) begin
          m_vk[e] = bus.cdb_data; m_qk[e] = 3'd0;
        end else begin
          m_vk[e] = bus.disp_vk; m_qk[e] = bus.disp_qk;
        end
      end
    end
    m_held = ((off >= 0) && !bus.fu_ready) ? off : -1;
  endtask

  initial begin
    mt[0] = 3'd5;
    mt[1] = 3'd6;
    // Columns: dv, rs, op, vj, vk, qj, qk, cv, ct, cd, fu, exp busy, valid, op, a, b, tag
    tbl[0]  = mk(1, 3'd5, 4'h0, 32'd5,    32'd7,    3'd0, 3'd0, 0, 3'd0, 32'h0,  0, 2'b01, 1, 4'h0, 32'd5,    32'd7,    3'd5);
    tbl[1]  = mk(0, 3'd0, 4'h0, 32'd0,    32'd0,    3'd0, 3'd0, 0, 3'd0, 32'h0,  1, 2'b00, 0, 4'h0, 32'd0,    32'd0,    3'd0);
    tbl[2]  = mk(1, 3'd6, 4'h3, 32'h11,   32'h22,   3'd3, 3'd0, 0, 3'd0, 32'h0,  1, 2'b10, 0, 4'h0, 32'd0,    32'd0,    3'd0);
    tbl[3]  = mk(0, 3'd0, 4'h0, 32'd0,    32'd0,    3'd0, 3'd0, 0, 3'd0, 32'h0,  1, 2'b10, 0, 4'h0, 32'd0,    32'd0,    3'd0);
    tbl[4]  = mk(0, 3'd0, 4'h0, 32'd0,    32'd0,    3'd0, 3'd0, 1, 3'd3, 32'h20, 1, 2'b10, 1, 4'h3, 32'h20,   32'h22,   3'd6);
    tbl[5]  = mk(0, 3'd0, 4'h0, 32'd0,    32'd0,    3'd0, 3'd0, 0, 3'd0, 32'h0,  1, 2'b00, 0, 4'h0, 32'd0,    32'd0,    3'd0);
    tbl[6]  = mk(1, 3'd5, 4'h7, 32'd1,    32'd2,    3'd0, 3'd4, 1, 3'd4, 32'h99, 0, 2'b01, 1, 4'h7, 32'd1,    32'h99,   3'd5);
    tbl[7]  = mk(0, 3'd0, 4'h0, 32'd0,    32'd0,    3'd0, 3'd0, 0, 3'd0, 32'h0,  1, 2'b00, 0, 4'h0, 32'd0,    32'd0,    3'd0);
    tbl[8]  = mk(1, 3'd5, 4'h2, 32'h10,   32'h30,   3'd0, 3'd2, 0, 3'd0, 32'h0,  1, 2'b01, 0, 4'h0, 32'd0,    32'd0,    3'd0);
    tbl[9]  = mk(1, 3'd5, 4'h9, 32'hAA,   32'hBB,   3'd0, 3'd0, 0, 3'd0, 32'h0,  1, 2'b01, 0, 4'h0, 32'd0,    32'd0,    3'd0);
    tbl[10] = mk(0, 3'd0, 4'h0, 32'd0,    32'd0,    3'd0, 3'd0, 1, 3'd2, 32'h44, 0, 2'b01, 1, 4'h2, 32'h10,   32'h44,   3'd5);
    tbl[11] = mk(0, 3'd0, 4'h0, 32'd0,    32'd0,    3'd0, 3'd0, 0, 3'd0, 32'h0,  1, 2'b00, 0, 4'h0, 32'd0,    32'd0,    3'd0);
    tbl[12] = mk(1, 3'd6, 4'h1, 32'd3,    32'd4,    3'd0, 3'd1, 0, 3'd0, 32'h0,  1, 2'b10, 0, 4'h0, 32'd0,    32'd0,    3'd0);
    tbl[13] = mk(0, 3'd0, 4'h0, 32'd0,    32'd0,    3'd0, 3'd0, 1, 3'd0, 32'h55, 1, 2'b10, 0, 4'h0, 32'd0,    32'd0,    3'd0);
    tbl[14] = mk(1, 3'd0, 4'h4, 32'd9,    32'd9,    3'd0, 3'd0, 1, 3'd1, 32'h66, 0, 2'b10, 1, 4'h1, 32'd3,    32'h66,   3'd6);
    tbl[15] = mk(0, 3'd0, 4'h0, 32'd0,    32'd0,    3'd0, 3'd0, 0, 3'd0, 32'h0,  1, 2'b00, 0, 4'h0, 32'd0,    32'd0,    3'd0);
    tbl[16] = mk(1, 3'd3, 4'h5, 32'd1,    32'd1,    3'd0, 3'd0, 0, 3'd0, 32'h0,  1, 2'b00, 0, 4'h0, 32'd0,    32'd0,    3'd0);

    drv(0, 3'd0, 4'h0, 32'd0, 32'd0, 3'd0, 3'd0, 0, 3'd0, 32'd0, 0);
    repeat (2) @(negedge clk);
    check("reset", 2'b00, 1'b0, 4'h0, 32'd0, 32'd0, 3'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drv(tbl[i].dv, tbl[i].rs, tbl[i].op, tbl[i].vj, tbl[i].vk, tbl[i].qj, tbl[i].qk,
          tbl[i].cv, tbl[i].ct, tbl[i].cd, tbl[i].fu);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].eb, tbl[i].ev, tbl[i].eo, tbl[i].ea, tbl[i].ebv, tbl[i].et);
    end

    // Stalled offer holds A while B is also ready. Then A issues and B issues.
    drv(1, 3'd5, 4'h5, 32'd1, 32'd2, 3'd0, 3'd0, 0, 3'd0, 32'd0, 0);
    @(negedge clk);
    check("stall_dispA", 2'b01, 1'b1, 4'h5, 32'd1, 32'd2, 3'd5);
    drv(1, 3'd6, 4'h6, 32'd3, 32'd4, 3'd0, 3'd0, 0, 3'd0, 32'd0, 0);
    @(negedge clk);
    check("stall_dispB", 2'b11, 1'b1, 4'h5, 32'd1, 32'd2, 3'd5);
    drv(0, 3'd0, 4'h0, 32'd0, 32'd0, 3'd0, 3'd0, 0, 3'd0, 32'd0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall_hold%0d", c), 2'b11, 1'b1, 4'h5, 32'd1, 32'd2, 3'd5);
    end
    bus.fu_ready = 1'b1;
    @(negedge clk);
    check("stall_fireA", 2'b10, 1'b1, 4'h6, 32'd3, 32'd4, 3'd6);
    @(negedge clk);
    check("stall_fireB", 2'b00, 1'b0, 4'h0, 32'd0, 32'd0, 3'd0);

    // Asynchronous reset mid-cycle with both entries busy.
    drv(1, 3'd5, 4'h8, 32'd8, 32'd9, 3'd0, 3'd0, 0, 3'd0, 32'd0, 0);
    @(negedge clk);
    drv(1, 3'd6, 4'h1, 32'd1, 32'd1, 3'd7, 3'd0, 0, 3'd0, 32'd0, 0);
    @(negedge clk);
    check("pre_reset", 2'b11, 1'b1, 4'h8, 32'd8, 32'd9, 3'd5);
    drv(0, 3'd0, 4'h0, 32'd0, 32'd0, 3'd0, 3'd0, 0, 3'd0, 32'd0, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset", 2'b00, 1'b0, 4'h0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    check("reset_held", 2'b00, 1'b0, 4'h0, 32'd0, 32'd0, 3'd0);
    rst_n = 1'b1;
    drv(1, 3'd5, 4'hC, 32'h12, 32'h34, 3'd0, 3'd0, 0, 3'd0, 32'd0, 0);
    @(negedge clk);
    check("first_disp", 2'b01, 1'b1, 4'hC, 32'h12, 32'h34, 3'd5);

    // Randomized run against the reference model, starting from a fresh reset.
    drv(0, 3'd0, 4'h0, 32'd0, 32'd0, 3'd0, 3'd0, 0, 3'd0, 32'd0, 0);
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] rs;
      int r;
      m_check($sformatf("rand%0d", n));
      r = $urandom_range(0, 5);
      rs = (r < 2) ? 3'd5 : (r < 4) ? 3'd6 : 3'($urandom_range(0, 7));
      drv(1'($urandom_range(0, 1)), rs, 4'($urandom_range(0, 15)), $urandom, $urandom,
          ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
          ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
      m_step();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rs_alu_pair.md
RS_ALU_PAIR -- requirements
Module: rs_alu_pair

Interface
REQ-001 SHALL have parameter TAG_A, default 3'd5 (ALU_1), the tag owned by entry A.
REQ-002 SHALL have parameter TAG_B, default 3'd6 (ALU_2), the tag owned by entry B.
REQ-003 SHALL have parameter XLEN, default 32, the operand and data width.
REQ-004 CLK  in  1  sole clock; all state changes on rising edge.
REQ-005 RST_N  in  1  reset, asynchronous and active-low.
REQ-006 DISP_VALID  in  1  issue queue presents a task this cycle.
REQ-007 DISP_RS  in  3  destination RS tag (0 = INVALID).
REQ-008 DISP_OP  in  4  ALU function code.
REQ-009 DISP_VJ / DISP_VK  in  XLEN each  operand values.
REQ-010 DISP_QJ / DISP_QK  in  3 each  producer tags; 0 means the operand is already valid.
REQ-011 CDB_VALID  in  1  common data bus broadcast is valid.
REQ-012 CDB_TAG  in  3  producing RS tag.
REQ-013 CDB_DATA  in  XLEN  result value.
REQ-014 FU_READY  in  1  ALU accepts an operation this cycle.
REQ-015 BUSY  out  2  [0] = entry A occupied, [1] = entry B occupied; feeds issue queue rs_busy[5:4].
REQ-016 ISSUE_VALID  out  1  an operation is offered to the ALU.
REQ-017 ISSUE_OP  out  4  function code of the offered operation.
REQ-018 ISSUE_A / ISSUE_B  out  XLEN each  resolved operands.
REQ-019 ISSUE_TAG  out  3  tag of the issuing entry; the ALU uses it on the CDB.

Function
REQ-020 Each entry SHALL hold state FREE, WAIT or READY, plus op, Vj, Vk, Qj, Qk and an age bit.
REQ-021 Dispatch to an entry SHALL occur when DISP_VALID=1, DISP_RS equals that entry's tag, and the entry is FREE.
REQ-022 Dispatch to an entry that is not FREE SHALL be ignored, leaving no state change.
REQ-023 DISP_RS values not equal to TAG_A or TAG_B SHALL be ignored.
REQ-024 On dispatch, an operand SHALL be captured from CDB_DATA with Q cleared to 0 when its Q is nonzero and CDB_VALID=1 with CDB_TAG equal to that Q (same-cycle bypass); otherwise DISP_V and DISP_Q SHALL be stored.
REQ-025 A dispatched entry SHALL enter READY if both stored Q are 0 after REQ-024, else WAIT.
REQ-026 Each cycle, for an entry in WAIT with CDB_VALID=1, every operand whose Q equals CDB_TAG SHALL load CDB_DATA and clear Q to 0.
REQ-027 An entry in WAIT SHALL move to READY on the edge at which its last nonzero Q clears.
REQ-028 CDB_TAG=0 SHALL never match an operand.
REQ-029 Minimum dispatch-to-ISSUE_VALID latency SHALL be 1 cycle.
REQ-030 ISSUE_VALID SHALL be 1 whenever any entry is READY, driven combinationally from registered state.
REQ-031 With both entries READY, the older entry (dispatched earlier) SHALL be selected.
REQ-032 Because at most one dispatch occurs per cycle, ages SHALL never tie.
REQ-033 Handshake: fire = ISSUE_VALID & FU_READY; on fire, the selected entry SHALL return to FREE at that edge.
REQ-034 Its BUSY bit SHALL drop the following cycle.
REQ-035 While ISSUE_VALID=1 and FU_READY=0, the selection and ISSUE_OP, ISSUE_A, ISSUE_B and ISSUE_TAG SHALL hold stable; a younger entry becoming READY SHALL NOT displace it.
REQ-036 An entry freed by fire SHALL NOT be re-dispatched in the same cycle; DISP is evaluated against pre-edge state.
REQ-037 BUSY[i] SHALL be 1 iff entry i is not FREE.
REQ-038 When ISSUE_VALID=0, ISSUE_OP, ISSUE_A, ISSUE_B and ISSUE_TAG SHALL be 0.

Reset
REQ-039 While RST_N=0, both entries SHALL be FREE and all stored fields 0, so BUSY=2'b00, ISSUE_VALID=0 and all issue outputs are 0, independent of CLK.
REQ-040 Reset asserted mid-operation SHALL discard WAIT and READY entries immediately, and no fire SHALL occur in that cycle.
REQ-041 The first dispatch SHALL be accepted on the first rising edge after RST_N deasserts.

Verification
REQ-042 Dispatch TAG_A, op 4'h0, VJ=5, VK=7, QJ=QK=0 -> BUSY=01 next cycle; ISSUE_VALID=1, A=5, B=7, TAG=5; with FU_READY=1, BUSY=00 the cycle after.
REQ-043 Dispatch TAG_B with QJ=3; two cycles later CDB(tag 3, data 0x20) -> ISSUE_VALID rises the cycle after the CDB, with ISSUE_A=0x20.
REQ-044 Dispatch TAG_A with QK=4 in the same cycle as CDB(tag 4, 0x99) -> READY next cycle, with ISSUE_B=0x99 (bypass).
REQ-045 A then B dispatched ready with FU_READY=0 for 3 cycles -> ISSUE_TAG=5 held stable; FU_READY=1 -> A issues, then B issues next cycle.
REQ-046 Dispatch to TAG_A while A is in WAIT -> ignored, and A's stored operands are unchanged.
REQ-047 Both entries busy, RST_N pulsed low mid-cycle -> BUSY=00 and ISSUE_VALID=0 asynchronously.
